// File: rtl/avalon_cmd_engine_pkg.sv
// Shared constants for the Avalon-MM command engine: register map, opcodes,
// STATUS bit positions, FSM encoding and the block ID.
package avalon_cmd_engine_pkg;

    localparam logic [31:0] ADDR_ID       = 32'h00;
    localparam logic [31:0] ADDR_CMD      = 32'h01;
    localparam logic [31:0] ADDR_STATUS   = 32'h02;
    localparam logic [31:0] ADDR_IRQ_EN   = 32'h03;
    localparam logic [31:0] ADDR_KEY      = 32'h04;
    localparam logic [31:0] ADDR_IN_BASE  = 32'h10;
    localparam logic [31:0] ADDR_OUT_BASE = 32'h20;

    localparam logic [3:0] OP_NOT  = 4'd1;
    localparam logic [3:0] OP_COPY = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;

    localparam int ST_DONE     = 0;
    localparam int ST_BUSY     = 1;
    localparam int ST_ERR_CMD  = 2;
    localparam int ST_ERR_BUSY = 3;

    localparam logic [31:0] ID_VALUE = 32'h0002_0001;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_NOT) || (op == OP_COPY) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/avalon_cmd_engine_if.sv
// Avalon-MM slave bus bundle between the host and the command engine.
interface avalon_cmd_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] avalon_slave_address;
    logic              avalon_slave_read;
    logic [DATA_W-1:0] avalon_slave_readdata;
    logic              avalon_slave_write;
    logic [DATA_W-1:0] avalon_slave_writedata;

    modport master (
        output avalon_slave_address,
        output avalon_slave_read,
        output avalon_slave_write,
        output avalon_slave_writedata,
        input  avalon_slave_readdata
    );

    modport slave (
        input  avalon_slave_address,
        input  avalon_slave_read,
        input  avalon_slave_write,
        input  avalon_slave_writedata,
        output avalon_slave_readdata
    );
endinterface

// File: rtl/cmd_lane_alu.sv
// One-lane transform used by the engine; unknown opcodes never reach RUN, so
// the default arm simply passes the lane through.
module cmd_lane_alu
    import avalon_cmd_engine_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [3:0]        opcode,
    input  logic [LANE_W-1:0] in_lane,
    input  logic [LANE_W-1:0] key_lane,
    output logic [LANE_W-1:0] out_lane
);

    // Select the lane operation.
    always_comb begin
        case (opcode)
            OP_NOT:  out_lane = ~in_lane;
            OP_XOR:  out_lane = in_lane ^ key_lane;
            default: out_lane = in_lane;
        endcase
    end

endmodule

// File: rtl/avalon_cmd_engine.sv
// Avalon-MM command engine: register file, word buffers, lane-serial
// transform FSM and level interrupt.
//
//   state  | meaning
//   IDLE   | waiting for a legal CMD write
//   RUN    | one lane of one word transformed per clock
//   FINISH | single clock: set DONE, drop BUSY
module avalon_cmd_engine
    import avalon_cmd_engine_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                clock_sink_clk,
    input  logic                reset_sink_resetn,
    avalon_cmd_engine_if.slave  avs,
    output logic                irq
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int LP_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              err_cmd_q, err_cmd_d;
    logic              err_busy_q, err_busy_d;
    logic [1:0]        irq_en_q, irq_en_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [3:0]        op_q, op_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [LP_W-1:0]   lp_q, lp_d;
    logic [WP_W-1:0]   wp_q, wp_d;
    logic [DATA_W-1:0] in_q  [DEPTH];
    logic [DATA_W-1:0] in_d  [DEPTH];
    logic [DATA_W-1:0] out_q [DEPTH];
    logic [DATA_W-1:0] out_d [DEPTH];
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              irq_q, irq_d;

    logic [31:0]       addr_ext;
    logic [WP_W-1:0]   buf_idx;
    logic              in_hit, out_hit;
    logic [DATA_W-1:0] wd;
    logic              cmd_legal;
    logic [31:0]       lane_base;
    logic [LANE_W-1:0] in_lane, key_lane, alu_out;
    logic              last_lane;
    logic [3:0]        status_vec;
    logic [DATA_W-1:0] rd_mux;

    assign addr_ext  = 32'(avs.avalon_slave_address);
    assign buf_idx   = addr_ext[WP_W-1:0];
    assign in_hit    = (addr_ext >= ADDR_IN_BASE)  && (addr_ext < ADDR_IN_BASE  + 32'(DEPTH));
    assign out_hit   = (addr_ext >= ADDR_OUT_BASE) && (addr_ext < ADDR_OUT_BASE + 32'(DEPTH));
    assign wd        = avs.avalon_slave_writedata;
    assign cmd_legal = op_legal(wd[3:0]) && (wd[11:8] != 4'd0) && (32'(wd[11:8]) <= 32'(DEPTH));

    assign lane_base = 32'(lp_q) * 32'(LANE_W);
    assign in_lane   = in_q[wp_q][lane_base +: LANE_W];
    assign key_lane  = key_q[lane_base +: LANE_W];
    assign last_lane = (lp_q == LP_W'(LANES - 1)) && ((32'(wp_q) + 32'd1) == 32'(cnt_q));

    cmd_lane_alu #(.LANE_W(LANE_W)) u_alu (
        .opcode   (op_q),
        .in_lane  (in_lane),
        .key_lane (key_lane),
        .out_lane (alu_out)
    );

    // Assemble the STATUS word from its individual flags.
    always_comb begin
        status_vec              = '0;
        status_vec[ST_DONE]     = done_q;
        status_vec[ST_BUSY]     = busy_q;
        status_vec[ST_ERR_CMD]  = err_cmd_q;
        status_vec[ST_ERR_BUSY] = err_busy_q;
    end

    // Read data mux; CMD is write-only and unmapped addresses return zero.
    always_comb begin
        rd_mux = '0;
        if (addr_ext == ADDR_ID)          rd_mux = DATA_W'(ID_VALUE);
        else if (addr_ext == ADDR_STATUS) rd_mux = DATA_W'(status_vec);
        else if (addr_ext == ADDR_IRQ_EN) rd_mux = DATA_W'(irq_en_q);
        else if (addr_ext == ADDR_KEY)    rd_mux = key_q;
        else if (in_hit)                  rd_mux = in_q[buf_idx];
        else if (out_hit)                 rd_mux = out_q[buf_idx];
    end

    // Next-state for registers, buffers and FSM; hardware sets come after W1C so they win.
    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        busy_d     = busy_q;
        err_cmd_d  = err_cmd_q;
        err_busy_d = err_busy_q;
        irq_en_d   = irq_en_q;
        key_d      = key_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        lp_d       = lp_q;
        wp_d       = wp_q;
        in_d       = in_q;
        out_d      = out_q;
        readdata_d = avs.avalon_slave_read ? rd_mux : readdata_q;

        if (avs.avalon_slave_write) begin
            if (addr_ext == ADDR_STATUS) begin
                if (wd[ST_DONE])     done_d     = 1'b0;
                if (wd[ST_ERR_CMD])  err_cmd_d  = 1'b0;
                if (wd[ST_ERR_BUSY]) err_busy_d = 1'b0;
            end
            if (addr_ext == ADDR_IRQ_EN) irq_en_d = wd[1:0];
            if ((addr_ext == ADDR_KEY) || (addr_ext == ADDR_CMD) || in_hit) begin
                if (busy_q) begin
                    err_busy_d = 1'b1;
                end else if (addr_ext == ADDR_KEY) begin
                    key_d = wd;
                end else if (in_hit) begin
                    in_d[buf_idx] = wd;
                end else if (cmd_legal) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    op_d    = wd[3:0];
                    cnt_d   = wd[11:8];
                    lp_d    = '0;
                    wp_d    = '0;
                end else begin
                    err_cmd_d = 1'b1;
                end
            end
        end

        case (state_q)
            S_RUN: begin
                out_d[wp_q][lane_base +: LANE_W] = alu_out;
                if (last_lane) begin
                    state_d = S_FINISH;
                end else if (lp_q == LP_W'(LANES - 1)) begin
                    lp_d = '0;
                    wp_d = wp_q + WP_W'(1);
                end else begin
                    lp_d = lp_q + LP_W'(1);
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        irq_d = (done_q & irq_en_q[0]) | ((err_cmd_q | err_busy_q) & irq_en_q[1]);
    end

    // State and register update; reset clears everything and aborts any run.
    always_ff @(posedge clock_sink_clk or negedge reset_sink_resetn) begin
        if (!reset_sink_resetn) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_cmd_q  <= 1'b0;
            err_busy_q <= 1'b0;
            irq_en_q   <= '0;
            key_q      <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            lp_q       <= '0;
            wp_q       <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                in_q[i]  <= '0;
                out_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_cmd_q  <= err_cmd_d;
            err_busy_q <= err_busy_d;
            irq_en_q   <= irq_en_d;
            key_q      <= key_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            lp_q       <= lp_d;
            wp_q       <= wp_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            in_q       <= in_d;
            out_q      <= out_d;
        end
    end

    assign avs.avalon_slave_readdata = readdata_q;
    assign irq                       = irq_q;

endmodule
